// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types, defaults and priority-encode helper for the serial bus arbiter
package arbiter_pkg;

  localparam int MAX_MASTERS             = 4;
  localparam int IDX_W                   = $clog2(MAX_MASTERS);
  localparam int DEF_NUM_MASTERS         = 2;
  localparam int DEF_MIN_HOLD            = 4;
  localparam int DEF_PREEMPT_TIMEOUT     = 8;
  localparam int DEF_TURNAROUND          = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    PREEMPT = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } prio_t;

  // Scan from the top down so the lowest set index is the one left standing.
  function automatic prio_t prio_encode(input logic [MAX_MASTERS-1:0] req);
    prio_t r;
    r = '0;
    for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_prio_encoder.sv
// rtl/arb_prio_encoder.sv - combinational lowest-index request select with found flag
module arb_prio_encoder
  import arbiter_pkg::*;
#(
  parameter int N       = DEF_NUM_MASTERS,
  parameter int OWNER_W = 1
) (
  input  logic [N-1:0]       req,
  output logic [OWNER_W-1:0] idx,
  output logic               found
);

  logic [MAX_MASTERS-1:0] req_pad;
  prio_t                  res;

  always_comb begin
    req_pad = '0;
    for (int i = 0; i < N; i++) begin
      req_pad[i] = req[i];
    end
    res   = prio_encode(req_pad);
    idx   = OWNER_W'(res.idx);
    found = res.found;
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// rtl/serial_bus_arbiter.sv - fixed-priority serial bus arbiter with preemption and forced-revoke timeout
module serial_bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = DEF_NUM_MASTERS,
  parameter int MIN_HOLD        = DEF_MIN_HOLD,
  parameter int PREEMPT_TIMEOUT = DEF_PREEMPT_TIMEOUT,
  parameter int TURNAROUND      = DEF_TURNAROUND,
  localparam int OWNER_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] arbSend,
  output logic [NUM_MASTERS-1:0] arbCont,
  output logic [OWNER_W-1:0]     busOwner,
  output logic                   busValid,
  output logic                   timeoutErr
);

  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int WAIT_W = (PREEMPT_TIMEOUT > 1) ? $clog2(PREEMPT_TIMEOUT) : 1;
  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PREEMPT_TIMEOUT - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] cont_q, cont_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic                   valid_q, valid_d;
  logic                   terr_q, terr_d;
  logic [HOLD_W-1:0]      hold_q, hold_d, hold_inc;
  logic [WAIT_W-1:0]      wait_q, wait_d, wait_inc;
  logic [TURN_W-1:0]      turn_q, turn_d;
  logic [NUM_MASTERS-1:0] blocked_q, blocked_d;

  logic [NUM_MASTERS-1:0] req;
  logic [OWNER_W-1:0]     enc_idx;
  logic                   enc_found;
  logic                   higher_req;

  assign req = arbSend & ~blocked_q;

  arb_prio_encoder #(
    .N       (NUM_MASTERS),
    .OWNER_W (OWNER_W)
  ) u_enc (
    .req   (req),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cont_q    <= '0;
      owner_q   <= '0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
      hold_q    <= '0;
      wait_q    <= '0;
      turn_q    <= '0;
      blocked_q <= '0;
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      terr_q    <= terr_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      turn_q    <= turn_d;
      blocked_q <= blocked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cont_d     = cont_q;
    owner_d    = owner_q;
    valid_d    = valid_q;
    terr_d     = 1'b0;
    hold_d     = hold_q;
    wait_d     = wait_q;
    turn_d     = turn_q;
    // A block lifts as soon as the master is seen idle.
    blocked_d  = blocked_q & arbSend;
    hold_inc   = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    wait_inc   = (wait_q == WAIT_LAST) ? wait_q : wait_q + 1'b1;
    higher_req = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (req[j] && (j < int'(owner_q))) higher_req = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enc_found) begin
          state_d          = GRANT;
          cont_d           = '0;
          cont_d[enc_idx]  = 1'b1;
          owner_d          = enc_idx;
          valid_d          = 1'b1;
          hold_d           = '0;
        end
      end
      GRANT: begin
        hold_d = hold_inc;
        // Release wins over a coincident higher-priority request.
        if (!arbSend[owner_q]) begin
          cont_d  = '0;
          valid_d = 1'b0;
          turn_d  = '0;
          state_d = TURN;
        end else if (higher_req && (hold_inc == HOLD_MAX)) begin
          cont_d  = '0;
          wait_d  = '0;
          state_d = PREEMPT;
        end
      end
      PREEMPT: begin
        if (!arbSend[owner_q]) begin
          valid_d = 1'b0;
          turn_d  = '0;
          state_d = TURN;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LAST) begin
            terr_d             = 1'b1;
            blocked_d[owner_q] = 1'b1;
            valid_d            = 1'b0;
            turn_d             = '0;
            state_d            = TURN;
          end
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) state_d = IDLE;
        else                     turn_d  = turn_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arbCont    = cont_q;
  assign busOwner   = owner_q;
  assign busValid   = valid_q;
  assign timeoutErr = terr_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb/tb_serial_bus_arbiter.sv - scoreboard bench for serial_bus_arbiter with directed scenarios
module tb_serial_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] arbSend = 2'b00;
  logic [1:0] arbCont;
  logic       busOwner;
  logic       busValid;
  logic       timeoutErr;

  int cyc    = 0;
  int base   = 0;
  int scn    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         edge_n;
    int         scn_id;
    logic [1:0] cont;
    logic       owner;
    logic       valid;
    logic       terr;
  } exp_t;

  exp_t exp_q[$];

  serial_bus_arbiter #(
    .NUM_MASTERS     (2),
    .MIN_HOLD        (4),
    .PREEMPT_TIMEOUT (8),
    .TURNAROUND      (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arbSend    (arbSend),
    .arbCont    (arbCont),
    .busOwner   (busOwner),
    .busValid   (busValid),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.edge_n != cyc || arbCont !== e.cont || busOwner !== e.owner ||
          busValid !== e.valid || timeoutErr !== e.terr) begin
        errors++;
        $display("FAIL s%0d edge %0d (at %0d): got cont=%b owner=%b valid=%b terr=%b, expected cont=%b owner=%b valid=%b terr=%b",
                 e.scn_id, e.edge_n - base, cyc - base, arbCont, busOwner, busValid, timeoutErr,
                 e.cont, e.owner, e.valid, e.terr);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_before(input int e, input logic [1:0] v);
    wait_cyc(base + e - 1);
    arbSend = v;
  endtask

  task automatic exp_at(input int e, input logic [1:0] c, input logic o, input logic v, input logic t);
    exp_t x;
    x.edge_n = base + e;
    x.scn_id = scn;
    x.cont   = c;
    x.owner  = o;
    x.valid  = v;
    x.terr   = t;
    exp_q.push_back(x);
  endtask

  // Reset is sampled at relative edge 1 and released from edge 2.
  task automatic start_scn(input int id);
    @(negedge clk);
    scn     = id;
    base    = cyc;
    rst     = 1'b1;
    arbSend = 2'b00;
    exp_at(1, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_cyc(base + 1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: basic grant and release
    start_scn(1);
    exp_at(4,  2'b00, 1'b0, 1'b0, 1'b0);
    exp_at(5,  2'b10, 1'b1, 1'b1, 1'b0);
    exp_at(11, 2'b10, 1'b1, 1'b1, 1'b0);
    exp_at(12, 2'b00, 1'b1, 1'b0, 1'b0);
    exp_at(13, 2'b00, 1'b1, 1'b0, 1'b0);
    set_before(5, 2'b10);
    set_before(12, 2'b00);
    wait_cyc(base + 14);

    // 2: preemption with a cooperative release
    start_scn(2);
    exp_at(5,  2'b10, 1'b1, 1'b1, 1'b0);
    exp_at(8,  2'b10, 1'b1, 1'b1, 1'b0);
    exp_at(9,  2'b00, 1'b1, 1'b1, 1'b0);
    exp_at(10, 2'b00, 1'b1, 1'b1, 1'b0);
    exp_at(11, 2'b00, 1'b1, 1'b0, 1'b0);
    exp_at(12, 2'b00, 1'b1, 1'b0, 1'b0);
    exp_at(13, 2'b01, 1'b0, 1'b1, 1'b0);
    set_before(5, 2'b10);
    set_before(7, 2'b11);
    set_before(11, 2'b01);
    wait_cyc(base + 14);

    // 3: forced revoke, block until master 1 drops its request
    start_scn(3);
    exp_at(9,  2'b00, 1'b1, 1'b1, 1'b0);
    exp_at(15, 2'b00, 1'b1, 1'b1, 1'b0);
    exp_at(16, 2'b00, 1'b1, 1'b0, 1'b1);
    exp_at(17, 2'b00, 1'b1, 1'b0, 1'b0);
    exp_at(18, 2'b01, 1'b0, 1'b1, 1'b0);
    exp_at(20, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_at(22, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_at(23, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_at(24, 2'b10, 1'b1, 1'b1, 1'b0);
    set_before(5, 2'b10);
    set_before(7, 2'b11);
    set_before(20, 2'b10);
    set_before(23, 2'b00);
    set_before(24, 2'b10);
    wait_cyc(base + 25);

    // 4: release on the same edge the timeout would fire
    start_scn(4);
    exp_at(15, 2'b00, 1'b1, 1'b1, 1'b0);
    exp_at(16, 2'b00, 1'b1, 1'b0, 1'b0);
    exp_at(17, 2'b00, 1'b1, 1'b0, 1'b0);
    exp_at(18, 2'b01, 1'b0, 1'b1, 1'b0);
    exp_at(19, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_at(20, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_at(21, 2'b10, 1'b1, 1'b1, 1'b0);
    set_before(5, 2'b10);
    set_before(7, 2'b11);
    set_before(16, 2'b01);
    set_before(19, 2'b10);
    wait_cyc(base + 22);

    // 5: simultaneous requests in IDLE
    start_scn(5);
    exp_at(3, 2'b01, 1'b0, 1'b1, 1'b0);
    set_before(3, 2'b11);
    wait_cyc(base + 4);

    // 6: release coinciding with a higher-priority request
    start_scn(6);
    exp_at(3,  2'b10, 1'b1, 1'b1, 1'b0);
    exp_at(8,  2'b10, 1'b1, 1'b1, 1'b0);
    exp_at(9,  2'b00, 1'b1, 1'b0, 1'b0);
    exp_at(10, 2'b00, 1'b1, 1'b0, 1'b0);
    exp_at(11, 2'b01, 1'b0, 1'b1, 1'b0);
    set_before(3, 2'b10);
    set_before(9, 2'b01);
    wait_cyc(base + 12);

    // 7: reset while in PREEMPT
    start_scn(7);
    exp_at(9,  2'b00, 1'b1, 1'b1, 1'b0);
    exp_at(10, 2'b00, 1'b1, 1'b1, 1'b0);
    exp_at(11, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_at(12, 2'b10, 1'b1, 1'b1, 1'b0);
    set_before(5, 2'b10);
    set_before(7, 2'b11);
    wait_cyc(base + 10);
    rst     = 1'b1;
    arbSend = 2'b10;
    wait_cyc(base + 11);
    rst = 1'b0;
    wait_cyc(base + 13);

    // 8: lower-priority request never preempts
    start_scn(8);
    exp_at(3, 2'b01, 1'b0, 1'b1, 1'b0);
    for (int e = 5; e < 55; e++) exp_at(e, 2'b01, 1'b0, 1'b1, 1'b0);
    set_before(3, 2'b01);
    set_before(5, 2'b11);
    wait_cyc(base + 56);

    arbSend = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
- Shares the serial bus between NUM_MASTERS masters with fixed priority; master 0 is highest.
- Each master requests on its 1-bit arbSend line and is granted or revoked on its 1-bit arbCont line.
- Drives the bus-mux select (busOwner/busValid) consumed by the interconnect.
- Supports preemption by a higher-priority master, with a forced-revoke timeout for a master that does not release.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..4)
MIN_HOLD, 4, cycles an owner keeps the bus before it can be preempted
PREEMPT_TIMEOUT, 8, cycles allowed between revoke and release before a forced revoke
TURNAROUND, 1, idle cycles with no owner between two grants (>=1)

Ports:
clk  input  1  clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
arbSend  input  NUM_MASTERS  per-master request level; high = wants or holds the bus
arbCont  output  NUM_MASTERS  per-master grant level; high = owns the bus, falling while owned = revoke
busOwner  output  $clog2(NUM_MASTERS) (min 1)  index of the current owner; mux select
busValid  output  1  high while any arbCont is high
timeoutErr  output  1  one-cycle pulse on a forced revoke

Behaviour:
- All outputs are registered.
- Reset values: arbCont=0, busOwner=0, busValid=0, timeoutErr=0, state=IDLE, counters=0, block mask=0.
- rst asserted mid-operation: at the next edge everything returns to reset values, including the mask. The bus is dropped with no revoke sequence.
- Effective request: req[i] = arbSend[i] & ~blocked[i].
- blocked[i] is set on a forced revoke of master i. It clears on the first edge that samples arbSend[i]=0.
- States: IDLE, GRANT, PREEMPT, TURN.
- IDLE:
  - If any req is high at edge k, pick the lowest index i.
  - At edge k: state=GRANT, arbCont[i]=1, busOwner=i, busValid=1, holdCnt=0.
  - The grant is visible in the cycle after the request is first sampled.
- GRANT (owner o):
  - holdCnt increments each cycle and saturates at MIN_HOLD.
  - arbSend[o]=0 sampled: arbCont=0, busValid=0, enter TURN. This is a normal release.
  - Else if req[j] with j<o and holdCnt>=MIN_HOLD: arbCont[o]=0, busValid stays 1, busOwner stays o, waitCnt=0, enter PREEMPT.
  - Lower-priority requests never preempt.
- PREEMPT:
  - The owner finishes its current word and then drops arbSend.
  - arbSend[o]=0 sampled: busValid=0, enter TURN.
  - Else waitCnt increments. When waitCnt reaches PREEMPT_TIMEOUT-1: timeoutErr=1 for one cycle, blocked[o]=1, busValid=0, enter TURN.
- TURN:
  - Lasts exactly TURNAROUND cycles with all arbCont=0 and busValid=0, then IDLE.
  - Requests seen during TURN are not granted until IDLE evaluates them.
- Simultaneous events:
  - Owner release and higher-priority request in the same cycle count as a release. No PREEMPT, no timeout.
  - Owner release on the same edge the timeout fires counts as a release. No error, no block.
  - A single request that stays high keeps its grant indefinitely (no time-slice).
- Width rules:
  - holdCnt is $clog2(MIN_HOLD+1) bits and waitCnt is $clog2(PREEMPT_TIMEOUT) bits; both saturate with no wrap.
  - busOwner holds its last value while busValid=0.

Decomposition:
- Shared package arbiter_pkg:
  - arb_state_t enum {IDLE, GRANT, PREEMPT, TURN}.
  - Function prio_encode(req) returning the lowest set index plus a found flag.
  - Default parameter constants.
- One sub-module, arb_prio_encoder: combinational lowest-index select with a found flag.
- The FSM and counters stay in the top module.

Test Plan (NUM_MASTERS=2, MIN_HOLD=4, PREEMPT_TIMEOUT=8, TURNAROUND=1):
1. Basic grant/release:
   - arbSend=2'b10 sampled at edge 5 -> arbCont=2'b10, busOwner=1, busValid=1 from edge 5.
   - arbSend[1]=0 at edge 12 -> arbCont=0 at 12, IDLE at 13.
2. Preemption:
   - Master 1 is granted at edge 5. arbSend[0] rises at edge 7.
   - -> arbCont[1] falls at edge 9 (holdCnt=4), busValid stays 1.
   - Master 1 releases at edge 11 -> arbCont=2'b01 at edge 13.
3. Forced timeout:
   - Same as scenario 2, but master 1 never releases.
   - -> timeoutErr pulses at edge 16, master 0 is granted at edge 18.
   - Master 1 stays ungranted until its arbSend is sampled 0 for one cycle and then re-raised.
4. Simultaneous requests and ties:
   - arbSend=2'b11 in IDLE -> master 0 is granted.
   - A master-0 request arriving on the same edge as master 1's release -> no PREEMPT entry, master 0 granted after TURN.
5. Reset mid-PREEMPT:
   - rst=1 for one cycle -> at the next edge all outputs are 0, state=IDLE, blocked=0.
   - With arbSend=2'b10 held, the grant reappears one cycle after rst deasserts.
6. No lower-priority preemption:
   - Master 0 is owner and arbSend[1]=1 for 50 cycles -> arbCont stays 2'b01 and timeoutErr stays 0 throughout.
